// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin arbiter that shares one single-port RAM among NUM_PORTS
// requesters. At most one transaction is granted per cycle. Read data comes
// back one cycle later, tagged with the port that issued the read. A port can
// lock the grant for a short atomic burst of at most MAX_LOCK transfers.
module ram_port_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_LOCK   = 8,
   localparam int PW        = $clog2(NUM_PORTS)
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS-1:0]             req_lock,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             req_ready,
   output logic                             rsp_valid,
   output logic [PW-1:0]                    rsp_port,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             ram_write_enable,
   output logic [ADDR_WIDTH-1:0]            ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_in_data,
   input  logic [DATA_WIDTH-1:0]            ram_out_data
);

   // Lock counter must be able to hold values up to MAX_LOCK.
   localparam int CW = $clog2(MAX_LOCK + 1);

   typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [PW-1:0]   r_owner;
   logic [PW-1:0]   w_owner_next;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_next;
   logic [CW-1:0]   w_count_inc;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_ptr_next;

   logic            w_grant_any;
   logic [PW-1:0]   w_grant;

   logic            r_rsp_valid;
   logic [PW-1:0]   r_rsp_port;

   logic [ADDR_WIDTH-1:0] w_addr  [NUM_PORTS];
   logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];

   // Unpack the flat per-port address and data buses.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
         assign w_addr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_wdata[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Port after p, wrapping modulo NUM_PORTS (handles non-power-of-two counts).
   function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
      return (int'(p) == NUM_PORTS - 1) ? '0 : p + PW'(1);
   endfunction

   assign w_count_inc = r_count + CW'(1);

   // Grant decode: the lock owner wins outright (or nobody does while it is
   // idle); otherwise pick the first valid port at or after the pointer.
   always_comb begin
      int          v_idx;
      logic [PW-1:0] v_sel;
      w_grant_any = 1'b0;
      w_grant     = '0;
      v_idx       = 0;
      v_sel       = '0;
      if (!reset) begin
         if (r_state == ST_LOCKED) begin
            if (req_valid[r_owner]) begin
               w_grant_any = 1'b1;
               w_grant     = r_owner;
            end
         end else begin
            // Scan from farthest to nearest so the nearest valid port wins.
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
               v_idx = int'(r_ptr) + k;
               if (v_idx >= NUM_PORTS) begin
                  v_idx = v_idx - NUM_PORTS;
               end
               v_sel = PW'(v_idx);
               if (req_valid[v_sel]) begin
                  w_grant_any = 1'b1;
                  w_grant     = v_sel;
               end
            end
         end
      end
   end

   // State register: lock state, owner, burst count and priority pointer.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_UNLOCKED;
         r_owner <= '0;
         r_count <= '0;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_next;
         r_owner <= w_owner_next;
         r_count <= w_count_next;
         r_ptr   <= w_ptr_next;
      end
   end

   // Next-state: enter, extend or release the lock and advance the pointer.
   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_count_next = r_count;
      w_ptr_next   = r_ptr;
      if (r_state == ST_LOCKED) begin
         if (req_valid[r_owner] && req_lock[r_owner] &&
             (w_count_inc < CW'(MAX_LOCK))) begin
            w_count_next = w_count_inc;
         end else begin
            // Owner went idle, dropped the lock, or used up its burst.
            w_state_next = ST_UNLOCKED;
            w_count_next = '0;
            w_ptr_next   = next_port(r_owner);
         end
      end else if (w_grant_any) begin
         // With MAX_LOCK = 1 the first locked transfer already exhausts the
         // burst, so the lock is never entered.
         if (req_lock[w_grant] && (MAX_LOCK > 1)) begin
            w_state_next = ST_LOCKED;
            w_owner_next = w_grant;
            w_count_next = CW'(1);
         end else begin
            w_ptr_next = next_port(w_grant);
         end
      end
   end

   // Outputs: one-hot ready and RAM pins driven by the granted port
   // (port 0 fields with write disabled when idle).
   always_comb begin
      req_ready = '0;
      if (w_grant_any) begin
         req_ready[w_grant] = 1'b1;
      end
      ram_write_enable = w_grant_any & req_write[w_grant];
      ram_addr         = w_addr[w_grant];
      ram_in_data      = w_wdata[w_grant];
   end

   // Read response: valid and port tag one cycle after a read transfer.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_port  <= '0;
      end else begin
         r_rsp_valid <= w_grant_any & ~req_write[w_grant];
         r_rsp_port  <= w_grant;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_port  = r_rsp_port;
   assign rsp_data  = ram_out_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed testbench for ram_port_arbiter with a behavioural single-port RAM
// (registered read, write updates the array on the same edge).
module tb_ram_port_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int AW = 10;

   logic              clock;
   logic              reset;
   logic [NP-1:0]     req_valid;
   logic [NP-1:0]     req_write;
   logic [NP-1:0]     req_lock;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*DW-1:0]  req_wdata;
   logic [NP-1:0]     req_ready;
   logic              rsp_valid;
   logic [1:0]        rsp_port;
   logic [DW-1:0]     rsp_data;
   logic              ram_write_enable;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_in_data;
   logic [DW-1:0]     ram_out_data;

   logic [AW-1:0]     addr_a  [NP];
   logic [DW-1:0]     wdata_a [NP];
   logic [DW-1:0]     mem [1024];

   int                n_checks;
   int                n_fail;
   logic              exp_rsp_valid;
   logic [1:0]        exp_rsp_port;

   logic [3:0]        rr_exp   [8];
   logic [3:0]        drop_exp [4];

   ram_port_arbiter #(
      .NUM_PORTS  (NP),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_LOCK   (8)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_write        (req_write),
      .req_lock         (req_lock),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_ready        (req_ready),
      .rsp_valid        (rsp_valid),
      .rsp_port         (rsp_port),
      .rsp_data         (rsp_data),
      .ram_write_enable (ram_write_enable),
      .ram_addr         (ram_addr),
      .ram_in_data      (ram_in_data),
      .ram_out_data     (ram_out_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Pack per-port fields onto the flat buses.
   always_comb begin
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < NP; i++) begin
         req_addr[i*AW +: AW]  = addr_a[i];
         req_wdata[i*DW +: DW] = wdata_a[i];
      end
   end

   // Behavioural single-port RAM.
   always @(posedge clock) begin
      if (ram_write_enable) mem[ram_addr] <= ram_in_data;
      ram_out_data <= mem[ram_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   // One clock cycle: drive inputs after the edge, check at the falling edge,
   // then record the response expected on the next cycle.
   task automatic do_cycle(input string tag, input logic rst, input logic [3:0] v,
                           input logic [3:0] w, input logic [3:0] l, input logic [3:0] exp_ready);
      @(posedge clock);
      #1;
      reset     = rst;
      req_valid = v;
      req_write = w;
      req_lock  = l;
      @(negedge clock);
      check_eq({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
      check_eq({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(exp_rsp_valid));
      if (exp_rsp_valid) check_eq({tag, "/rsp_port"}, 32'(rsp_port), 32'(exp_rsp_port));
      if (rst) check_eq({tag, "/we_in_reset"}, 32'(ram_write_enable), 32'd0);
      $display("%0t %-8s rst=%0b valid=%b write=%b lock=%b ready=%b rsp=%0b/%0d we=%0b addr=0x%0h",
               $time, tag, rst, v, w, l, req_ready, rsp_valid, rsp_port, ram_write_enable, ram_addr);
      exp_rsp_valid = (exp_ready != 4'b0000) && ((w & exp_ready) == 4'b0000);
      exp_rsp_port  = onehot_idx(exp_ready);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      exp_rsp_valid = 1'b0;
      exp_rsp_port  = 2'd0;
      reset         = 1'b1;
      req_valid     = '0;
      req_write     = '0;
      req_lock      = '0;
      for (int i = 0; i < NP; i++) begin
         addr_a[i]  = AW'(i * 4);
         wdata_a[i] = DW'(8'h10 + i);
      end
      rr_exp   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      drop_exp = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};

      // Reset held two cycles with every port requesting a write.
      do_cycle("rst", 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);
      do_cycle("rst", 1'b1, 4'hF, 4'hF, 4'h0, 4'h0);

      // Round-robin with all ports reading, then port 2 dropped.
      for (int i = 0; i < 8; i++) do_cycle("rr", 1'b0, 4'hF, 4'h0, 4'h0, rr_exp[i]);
      for (int i = 0; i < 4; i++) do_cycle("rr_drop2", 1'b0, 4'b1011, 4'h0, 4'h0, drop_exp[i]);

      // Port 1 writes 0xA5 to 0x010, port 3 reads it back next cycle.
      addr_a[1]  = 10'h010;
      wdata_a[1] = 8'hA5;
      addr_a[3]  = 10'h010;
      do_cycle("wr", 1'b0, 4'b0010, 4'b0010, 4'h0, 4'b0010);
      check_eq("wr/we", 32'(ram_write_enable), 32'd1);
      check_eq("wr/addr", 32'(ram_addr), 32'h010);
      check_eq("wr/wdata", 32'(ram_in_data), 32'hA5);
      do_cycle("rd", 1'b0, 4'b1000, 4'h0, 4'h0, 4'b1000);
      check_eq("rd/we", 32'(ram_write_enable), 32'd0);
      check_eq("rd/addr", 32'(ram_addr), 32'h010);
      do_cycle("rsp", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      check_eq("rsp/data", 32'(rsp_data), 32'hA5);
      check_eq("idle/we", 32'(ram_write_enable), 32'd0);
      check_eq("idle/addr", 32'(ram_addr), 32'h000);

      // Lock burst: move pointer to 2, then port 2 locks with everyone valid.
      do_cycle("pre", 1'b0, 4'b0010, 4'h0, 4'h0, 4'b0010);
      for (int i = 0; i < 8; i++) do_cycle("lock", 1'b0, 4'hF, 4'h0, 4'b0100, 4'b0100);
      do_cycle("lock_end", 1'b0, 4'hF, 4'h0, 4'b0100, 4'b1000);
      do_cycle("lock_end", 1'b0, 4'hF, 4'h0, 4'b0100, 4'b0001);

      // Lock release on idle: port 0 locks, then goes idle for a cycle.
      do_cycle("l0", 1'b0, 4'b0001, 4'h0, 4'b0001, 4'b0001);
      do_cycle("l0_hold", 1'b0, 4'b0011, 4'h0, 4'b0001, 4'b0001);
      do_cycle("l0_idle", 1'b0, 4'b0110, 4'h0, 4'h0, 4'b0000);
      do_cycle("l0_rel", 1'b0, 4'b0111, 4'h0, 4'h0, 4'b0010);

      // Reset mid-read while port 0 holds a lock.
      do_cycle("lk", 1'b0, 4'b0001, 4'h0, 4'b0001, 4'b0001);
      do_cycle("rst_mid", 1'b1, 4'b0001, 4'h0, 4'b0001, 4'b0000);
      do_cycle("post_rst", 1'b0, 4'b0010, 4'h0, 4'h0, 4'b0010);
      do_cycle("post_rst", 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares one `single_port_ram` instance among `NUM_PORTS` requesters. Each requester issues read or write transactions over a valid/ready handshake. The arbiter grants at most one transaction per cycle, drives the RAM address, data and write-enable pins, and returns read data tagged with the originating port one cycle later. An optional per-port lock gives short atomic bursts, bounded to prevent starvation.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: RAM word width.
- `ADDR_WIDTH`, 10: RAM address width.
- `MAX_LOCK`, 8: maximum consecutive locked grants to one port, ≥1.
- `PW` (localparam): `$clog2(NUM_PORTS)`.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_PORTS  port i has a transaction pending.
- `req_write`  in  NUM_PORTS  1 = write, 0 = read.
- `req_lock`  in  NUM_PORTS  request that port i keep the grant for its next transaction.
- `req_addr`  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_wdata`  in  NUM_PORTS*DATA_WIDTH  packed write data, packed the same way.
- `req_ready`  out  NUM_PORTS  one-hot or zero; port i's transaction is accepted this cycle.
- `rsp_valid`  out  1  read data is valid.
- `rsp_port`  out  PW  port that issued the read.
- `rsp_data`  out  DATA_WIDTH  read data.
- `ram_write_enable`  out  1  to RAM `write_enable`.
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`.
- `ram_in_data`  out  DATA_WIDTH  to RAM `in_data`.
- `ram_out_data`  in  DATA_WIDTH  from RAM `out_data`.

## Operation
- **Priority pointer.** A registered `ptr` (PW bits) holds the highest-priority port. The grant goes to the first port at or after `ptr`, wrapping modulo NUM_PORTS, that has `req_valid` high.
- **Grant decode.** The grant is combinational from `req_valid`, `ptr` and the lock state. `req_ready[g]` = 1 only for the granted port `g`. A transaction transfers when `req_valid[g] && req_ready[g]`.
- **RAM drive on transfer.** The selected port drives the RAM: `ram_addr` = addr[g], `ram_in_data` = wdata[g], `ram_write_enable` = `req_write[g]`.
- **RAM drive when idle.** With no valid request, `ram_write_enable` = 0 and `ram_addr` and `ram_in_data` hold the port-0 fields (don't-care).
- **Pointer update.** After a normal (unlocked) grant to `g`, `ptr` ← (g+1) mod NUM_PORTS. An idle cycle leaves `ptr` unchanged.
- **Lock states.**
  - UNLOCKED: normal round-robin.
  - LOCKED(owner, count): `owner` wins absolutely whenever `req_valid[owner]` is high.
- **Entering LOCKED.** A transfer from `g` with `req_lock[g]` = 1 in UNLOCKED moves to LOCKED(g, 1).
- **Staying LOCKED.** In LOCKED, a transfer by `owner` with `req_lock` = 1 and count < MAX_LOCK gives count+1.
- **Leaving LOCKED.** Return to UNLOCKED with `ptr` ← owner+1 when any of these occurs:
  - `owner` transfers with `req_lock` = 0;
  - `req_valid[owner]` = 0 in a cycle (no grant is made that cycle; the arbiter re-arbitrates the next cycle);
  - count = MAX_LOCK at a transfer. That transfer is honoured; the lock request is ignored.
- **MAX_LOCK = 1.** Locks never extend beyond one transfer.
- **Read response.** A read transfer sets `rsp_valid` = 1 and `rsp_port` = g on the next cycle. `rsp_data` is combinational from `ram_out_data`. There is no response backpressure; requesters must always accept.
- **Writes.** A write produces no response.
- **Same-address collision.** A read in the cycle after a write to the same address returns the new data, per RAM behaviour.

## Timing
- **Reset values:**
  - `ptr` = 0, state UNLOCKED, count = 0;
  - `rsp_valid` = 0, `rsp_port` = 0;
  - `req_ready` = 0 and `ram_write_enable` = 0 while `reset` is high.
- **Throughput.** One transaction per cycle; back-to-back reads give one response per cycle.
- **Read latency.** Exactly 1 cycle, from the transfer edge to `rsp_valid`.
- **Reset mid-operation.** A read transferred in the cycle `reset` rises produces no response. A write transferred in that cycle is suppressed. Lock and pointer return to reset values.
- **`req_ready` dependency.** `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **Hold rule.** A port with `req_valid` high and `req_ready` low must hold its addr, wdata, write and lock stable.

## Test plan
- **Reset.** Assert `reset` 2 cycles with all `req_valid` = 1 → `req_ready` = 0, `rsp_valid` = 0, `ram_write_enable` = 0. First cycle after: port 0 granted.
- **Round-robin fairness.** All 4 ports valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Drop port 2 → order skips 2.
- **Write then read.** Port 1 writes 0xA5 to addr 0x010, next cycle port 3 reads 0x010 → one cycle later `rsp_valid` = 1, `rsp_port` = 3, `rsp_data` = 0xA5.
- **Lock burst.** Port 2 holds `req_lock` = 1 for 12 reads while ports 0, 1 and 3 are valid → port 2 gets exactly 8 consecutive grants, then port 3, then 0.
- **Lock release on idle.** Port 0 locks, deasserts `req_valid` for one cycle → that cycle no grant. Next cycle port 1 wins.
- **Reset mid-read.** Port 0 read granted in the same cycle `reset` = 1 → `rsp_valid` stays 0 and the lock state clears.
